// File: rtl/remove_stuff.sv
// JPEG receive-side byte de-stuffer: drops the 8'h00 after 8'hff, detects markers and packs data into 32-bit words.
// Optional stuffed-byte counter port stuff_count is enabled by defining REMOVE_STUFF_COUNT_EN.
module remove_stuff #(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit DROP_FILL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    input  logic        out_ready,
    output logic        marker_valid,
    output logic [7:0]  marker_code
`ifdef REMOVE_STUFF_COUNT_EN
    ,
    output logic [15:0] stuff_count
`endif
);

    typedef enum logic {
        NORMAL = 1'b0,
        SAW_FF = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cnt;
    logic [2:0][7:0] acc;
    logic [3:0][7:0] all_bytes;

    logic            accept;
    logic            append;
    logic            stuffed;
    logic            marker;
    logic [7:0]      app_byte;
    logic            load_full;
    logic            flush;
    logic [2:0]      nbytes;
    logic [31:0]     word_nxt;
    logic [3:0]      keep_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal driven here is given a default first, so no latch is inferred.
        state_nxt = state;
        append    = 1'b0;
        stuffed   = 1'b0;
        marker    = 1'b0;
        app_byte  = in_data;
        if (accept) begin
            case (state)
                NORMAL: begin
                    if (in_data == 8'hff) state_nxt = SAW_FF;
                    else                  append    = 1'b1;
                end
                SAW_FF: begin
                    if (in_data == 8'h00) begin
                        append    = 1'b1;
                        app_byte  = 8'hff;
                        stuffed   = 1'b1;
                        state_nxt = NORMAL;
                    end else if (in_data == 8'hff) begin
                        append   = !DROP_FILL;
                        app_byte = 8'hff;
                    end else begin
                        marker    = 1'b1;
                        state_nxt = NORMAL;
                    end
                end
                default: state_nxt = NORMAL;
            endcase
        end
    end

    assign load_full = append && (cnt == 2'd3);
    assign flush     = marker && (cnt != 2'd0);
    assign all_bytes = {app_byte, acc};

    // A full word takes all three held bytes plus the incoming one; a marker flush takes only the held ones.
    always_comb begin
        nbytes   = load_full ? 3'd4 : {1'b0, cnt};
        word_nxt = '0;
        keep_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                if (MSB_FIRST) begin
                    word_nxt[31-8*i -: 8] = all_bytes[i];
                    keep_nxt[3-i]         = 1'b1;
                end else begin
                    word_nxt[8*i +: 8] = all_bytes[i];
                    keep_nxt[i]        = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (load_full || flush) cnt <= 2'd0;
            else if (append)        cnt <= cnt + 2'd1;
        end
    end

    // NOTE: the accumulator is data only, qualified by cnt, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (append && (cnt != 2'd3)) acc[cnt] <= app_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= 32'h0;
            out_keep     <= 4'h0;
            marker_valid <= 1'b0;
            marker_code  <= 8'h00;
        end else begin
            if (load_full || flush) begin
                out_valid <= 1'b1;
                out_data  <= word_nxt;
                out_keep  <= keep_nxt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_data  <= 32'h0;
                out_keep  <= 4'h0;
            end
            marker_valid <= marker;
            if (marker) marker_code <= in_data;
        end
    end

`ifdef REMOVE_STUFF_COUNT_EN
    // Counts removed stuffing bytes since the last marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                stuff_count <= 16'h0;
        else if (marker)                           stuff_count <= 16'h0;
        else if (stuffed && stuff_count != 16'hffff) stuff_count <= stuff_count + 16'h1;
    end
`endif

endmodule

// File: tb/tb_remove_stuff.sv
// Bench for remove_stuff: table vectors, hand sequences and a random stream against a queue-based model.
// Runs a DROP_FILL=1 instance and a DROP_FILL=0 instance fed with the same accepted bytes.
module tb_remove_stuff;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] bytes;
        logic [1:0]  nw;
        logic [31:0] w0;
        logic [3:0]  k0;
        logic [31:0] w1;
        logic [3:0]  k1;
        logic        has_m;
        logic [7:0]  mcode;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        int          cyc;
    } cap_t;

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } mcap_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_ready;
    logic        marker_valid;
    logic [7:0]  marker_code;

    logic        nf_in_valid;
    logic        nf_in_ready;
    logic        nf_out_valid;
    logic [31:0] nf_out_data;
    logic [3:0]  nf_out_keep;
    logic        nf_marker_valid;
    logic [7:0]  nf_marker_code;
`ifdef REMOVE_STUFF_COUNT_EN
    logic [15:0] stuff_count;
    logic [15:0] nf_stuff_count;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    // Reference model state: index 0 drops fill bytes, index 1 keeps them.
    bit          saw [2];
    logic [7:0]  pend_b [2][4];
    int          pend_n [2];
    word_t       exp_w0[$];
    word_t       exp_w1[$];
    logic [7:0]  exp_m0[$];
    logic [7:0]  exp_m1[$];
    logic [15:0] exp_cnt;

    cap_t  cap_w[$];
    cap_t  cap_nf[$];
    mcap_t cap_m[$];
    mcap_t cap_mnf[$];

    vec_t vecs [6];

    remove_stuff u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_ready(out_ready),
        .marker_valid(marker_valid), .marker_code(marker_code)
`ifdef REMOVE_STUFF_COUNT_EN
        , .stuff_count(stuff_count)
`endif
    );

    assign nf_in_valid = in_valid && in_ready;

    remove_stuff #(.MSB_FIRST(1'b1), .DROP_FILL(1'b0)) u_dut_nf (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nf_in_valid), .in_data(in_data), .in_ready(nf_in_ready),
        .out_valid(nf_out_valid), .out_data(nf_out_data), .out_keep(nf_out_keep), .out_ready(1'b1),
        .marker_valid(nf_marker_valid), .marker_code(nf_marker_code)
`ifdef REMOVE_STUFF_COUNT_EN
        , .stuff_count(nf_stuff_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic word_t pack_word(int m);
        word_t w;
        w.data = 32'h0;
        for (int i = 0; i < pend_n[m]; i++)
            w.data = w.data | (32'(pend_b[m][i]) << (24 - 8 * i));
        w.keep = 4'((8'hf0 >> pend_n[m]) & 8'h0f);
        return w;
    endfunction

    task automatic model_emit(int m);
        word_t w;
        w = pack_word(m);
        if (m == 0) exp_w0.push_back(w);
        else        exp_w1.push_back(w);
        pend_n[m] = 0;
    endtask

    task automatic model_append(int m, logic [7:0] b);
        pend_b[m][pend_n[m]] = b;
        pend_n[m]++;
        if (pend_n[m] == 4) model_emit(m);
    endtask

    task automatic model_byte(int m, logic [7:0] b);
        if (!saw[m]) begin
            if (b == 8'hff) saw[m] = 1'b1;
            else            model_append(m, b);
        end else if (b == 8'h00) begin
            model_append(m, 8'hff);
            saw[m] = 1'b0;
            if (m == 0 && exp_cnt != 16'hffff) exp_cnt++;
        end else if (b == 8'hff) begin
            if (m == 1) model_append(m, 8'hff);
        end else begin
            if (pend_n[m] > 0) model_emit(m);
            if (m == 0) begin
                exp_m0.push_back(b);
                exp_cnt = 16'h0;
            end else begin
                exp_m1.push_back(b);
            end
            saw[m] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            saw[m]    = 1'b0;
            pend_n[m] = 0;
        end
        exp_w0.delete();
        exp_w1.delete();
        exp_m0.delete();
        exp_m1.delete();
        exp_cnt = 16'h0;
    endtask

    // Scoreboard and capture, sampled mid-cycle where handshakes are stable.
    always @(negedge clk) begin
        cap_t  c;
        mcap_t mc;
        word_t w;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (out_valid && out_ready) begin
                c.data = out_data; c.keep = out_keep; c.cyc = cyc;
                cap_w.push_back(c);
                if (exp_w0.size() == 0) check("sb_word_unexpected", 32'd0, 32'd1);
                else begin
                    w = exp_w0.pop_front();
                    check("sb_word_data", out_data, w.data);
                    check("sb_word_keep", 32'(out_keep), 32'(w.keep));
                end
            end
            if (nf_out_valid) begin
                c.data = nf_out_data; c.keep = nf_out_keep; c.cyc = cyc;
                cap_nf.push_back(c);
                if (exp_w1.size() == 0) check("sb_nf_word_unexpected", 32'd0, 32'd1);
                else begin
                    w = exp_w1.pop_front();
                    check("sb_nf_word_data", nf_out_data, w.data);
                    check("sb_nf_word_keep", 32'(nf_out_keep), 32'(w.keep));
                end
            end
            if (marker_valid) begin
                mc.code = marker_code; mc.cyc = cyc;
                cap_m.push_back(mc);
                if (exp_m0.size() == 0) check("sb_marker_unexpected", 32'd0, 32'd1);
                else check("sb_marker_code", 32'(marker_code), 32'(exp_m0.pop_front()));
            end
            if (nf_marker_valid) begin
                mc.code = nf_marker_code; mc.cyc = cyc;
                cap_mnf.push_back(mc);
                if (exp_m1.size() == 0) check("sb_nf_marker_unexpected", 32'd0, 32'd1);
                else check("sb_nf_marker_code", 32'(nf_marker_code), 32'(exp_m1.pop_front()));
            end
`ifdef REMOVE_STUFF_COUNT_EN
            check("sb_stuff_count", 32'(stuff_count), 32'(exp_cnt));
`endif
            if (in_valid && in_ready) begin
                model_byte(0, in_data);
                model_byte(1, in_data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic clear_caps();
        cap_w.delete();
        cap_nf.delete();
        cap_m.delete();
        cap_mnf.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_keep"}, 32'(out_keep), 32'h0);
        check({tag, "_marker_valid"}, 32'(marker_valid), 32'd0);
        check({tag, "_marker_code"}, 32'(marker_code), 32'h0);
    endtask

    function automatic vec_t mk(int n, logic [63:0] bytes, int nw, logic [31:0] w0, logic [3:0] k0,
                                logic [31:0] w1, logic [3:0] k1, bit has_m, logic [7:0] mcode);
        vec_t v;
        v.n = 4'(n); v.bytes = bytes; v.nw = 2'(nw);
        v.w0 = w0; v.k0 = k0; v.w1 = w1; v.k1 = k1;
        v.has_m = has_m; v.mcode = mcode;
        return v;
    endfunction

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)       return 8'hff;
        else if (r < 5)  return 8'h00;
        else if (r == 5) return 8'hd0 + 8'($urandom_range(0, 9));
        else             return 8'($urandom);
    endfunction

    initial begin
        vecs[0] = mk(8, 64'h123456789abcdef0, 2, 32'h12345678, 4'hf, 32'h9abcdef0, 4'hf, 1'b0, 8'h00);
        vecs[1] = mk(5, 64'hff00010203000000, 1, 32'hff010203, 4'hf, 32'h0, 4'h0, 1'b0, 8'h00);
        vecs[2] = mk(4, 64'haabbffd900000000, 1, 32'haabb0000, 4'hc, 32'h0, 4'h0, 1'b1, 8'hd9);
        vecs[3] = mk(5, 64'h11ffffffd0000000, 1, 32'h11000000, 4'h8, 32'h0, 4'h0, 1'b1, 8'hd0);
        vecs[4] = mk(2, 64'hffd8000000000000, 0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b1, 8'hd8);
        vecs[5] = mk(5, 64'h010203ff00000000, 1, 32'h010203ff, 4'hf, 32'h0, 4'h0, 1'b0, 8'h00);

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            clear_caps();
            for (int j = 0; j < int'(vecs[i].n); j++) send_byte(vecs[i].bytes[63-8*j -: 8]);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("vec%0d_nwords", i), 32'(cap_w.size()), 32'(vecs[i].nw));
            if (cap_w.size() > 0) begin
                check($sformatf("vec%0d_w0", i), cap_w[0].data, vecs[i].w0);
                check($sformatf("vec%0d_k0", i), 32'(cap_w[0].keep), 32'(vecs[i].k0));
                check($sformatf("vec%0d_last_word_cycle", i), 32'(cap_w[cap_w.size()-1].cyc), 32'(last_acc));
            end
            if (vecs[i].nw == 2 && cap_w.size() > 1) begin
                check($sformatf("vec%0d_w1", i), cap_w[1].data, vecs[i].w1);
                check($sformatf("vec%0d_k1", i), 32'(cap_w[1].keep), 32'(vecs[i].k1));
                check($sformatf("vec%0d_word_gap", i), 32'(cap_w[1].cyc - cap_w[0].cyc), 32'd4);
            end
            check($sformatf("vec%0d_nmarkers", i), 32'(cap_m.size()), 32'(vecs[i].has_m));
            if (cap_m.size() > 0) begin
                check($sformatf("vec%0d_mcode", i), 32'(cap_m[0].code), 32'(vecs[i].mcode));
                check($sformatf("vec%0d_marker_cycle", i), 32'(cap_m[0].cyc), 32'(last_acc));
            end
            if (i == 3) begin
                check("nofill_nwords", 32'(cap_nf.size()), 32'd1);
                if (cap_nf.size() > 0) begin
                    check("nofill_word", cap_nf[0].data, 32'h11ffff00);
                    check("nofill_keep", 32'(cap_nf[0].keep), 32'he);
                end
                check("nofill_nmarkers", 32'(cap_mnf.size()), 32'd1);
                if (cap_mnf.size() > 0) check("nofill_mcode", 32'(cap_mnf[0].code), 32'hd0);
            end
        end

        // A dangling 8'hff must be held until the next byte arrives.
        clear_caps();
        send_byte(8'h7a);
        send_byte(8'hff);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("sawff_hold_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (2) @(posedge clk);
        #1;
        check("sawff_hold_nwords", 32'(cap_w.size()), 32'd1);
        if (cap_w.size() > 0) check("sawff_hold_word", cap_w[0].data, 32'h7aff0102);

        // Backpressure: a pending word blocks input, then the stream resumes losslessly.
        clear_caps();
        out_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        in_valid = 1'b1;
        in_data  = 8'h05;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", out_data, 32'h01020304);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        repeat (2) @(posedge clk);
        #1;
        check("bp_nwords", 32'(cap_w.size()), 32'd2);
        if (cap_w.size() > 1) begin
            check("bp_word0", cap_w[0].data, 32'h01020304);
            check("bp_word1", cap_w[1].data, 32'h05060708);
        end

        // Asynchronous reset with a word pending.
        out_ready = 1'b0;
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rst_pending");
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Asynchronous reset mid-word right after an 8'hff; the partial pack must vanish.
        clear_caps();
        send_byte(8'h55); send_byte(8'h66); send_byte(8'hff);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rst_sawff");
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_caps();
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        repeat (2) @(posedge clk);
        #1;
        check("rst_after_nwords", 32'(cap_w.size()), 32'd1);
        if (cap_w.size() > 0) check("rst_after_word", cap_w[0].data, 32'h00112233);
        check("rst_after_nmarkers", 32'(cap_m.size()), 32'd0);

        // Random stream with random backpressure against the model.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = pick_byte();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("drain_words_left", 32'(exp_w0.size()), 32'd0);
        check("drain_nf_words_left", 32'(exp_w1.size()), 32'd0);
        check("drain_markers_left", 32'(exp_m0.size()), 32'd0);
        check("drain_nf_markers_left", 32'(exp_m1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remove_stuff.md
Name: remove_stuff

Overview:
- Receive-side counterpart of the encoder's byte-stuffing stage.
- Consumes a JPEG entropy-coded byte stream, deletes the stuffed 8'h00 that follows each 8'hff, and detects markers (8'hff followed by a non-zero, non-ff byte).
- Repacks the surviving data bytes into 32-bit words, first byte in bits [31:24].
- Sits between the capture/DMA byte source and the Huffman decoder front end.

Parameters:
- MSB_FIRST, 1, 1 = first byte of a word lands in [31:24]; 0 = first byte lands in [7:0].
- DROP_FILL, 1, 1 = consecutive 8'hff fill bytes before a marker are discarded; 0 = each extra 8'hff in SAW_FF is emitted as a data byte 8'hff.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  in_data is valid
- in_data  input  8  stuffed byte stream
- in_ready  output  1  byte accepted when in_valid && in_ready
- out_valid  output  1  out_data holds a word
- out_data  output  32  destuffed packed word
- out_keep  output  4  byte-enable mask for out_data; 4'b1111 for full words
- out_ready  input  1  downstream accepts the word when out_valid && out_ready
- marker_valid  output  1  one-cycle pulse: marker detected
- marker_code  output  8  second byte of the detected marker (e.g. 8'hd9)

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_keep=0, marker_valid=0, marker_code=0, state=NORMAL, pack count=0. in_ready=1 after release.
- in_ready = !out_valid || out_ready (combinational); a byte is consumed only on in_valid && in_ready.
- State NORMAL:
  - byte != 8'hff -> append byte to the pack.
  - byte == 8'hff -> go to SAW_FF; nothing is appended.
- State SAW_FF:
  - 8'h00 -> append 8'hff; return to NORMAL.
  - 8'hff -> if DROP_FILL, drop it and stay in SAW_FF; otherwise append 8'hff and stay in SAW_FF.
  - Any other value v -> marker:
    - marker_valid=1 and marker_code=v on the next cycle, for exactly 1 cycle.
    - If the pack holds 1-3 bytes, flush them to the output register in the same cycle, with out_keep marking the valid bytes (MSB-aligned when MSB_FIRST) and unused bytes zero.
    - Return to NORMAL.
- Packing:
  - 3-byte accumulator plus count (0-3).
  - When a 4th byte is appended, {acc, byte} loads the output register with out_keep=4'b1111 and the count wraps to 0.
  - Latency: the word appears 1 cycle after the accepting edge of its 4th byte.
- Output register holds data stable while out_valid && !out_ready. It clears when the word is taken and no new load occurs in that cycle.
- Simultaneous take and load: out_ready=1 while the 4th byte is accepted -> the register reloads back-to-back with no bubble.
- A marker with count=0 produces marker_valid only; out_valid is unchanged.
- Stream ending in SAW_FF with no further input: hold SAW_FF indefinitely; no output.
- Reset mid-word or mid-SAW_FF discards the partial pack and the pending state.

Optional Feature:
- Macro: REMOVE_STUFF_COUNT_EN
- Defined:
  - Adds output port stuff_count[15:0], reset to 0.
  - Increments by 1 on each removed stuffed 8'h00; saturates at 16'hffff.
  - Clears to 0 on each marker_valid pulse.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Bytes 12 34 56 78 9a bc de f0, out_ready=1 -> words 32'h12345678 then 32'h9abcdef0, keep 4'b1111, 4 cycles apart.
- Bytes ff 00 01 02 03 -> word 32'hff010203; with COUNT_EN, stuff_count=1.
- Bytes aa bb ff d9 -> word 32'haabb0000 keep 4'b1100, plus marker_valid pulse with marker_code=8'hd9 in the same cycle.
- Bytes 11 ff ff ff d0 with DROP_FILL=1 -> keep 4'b1000 word 32'h11000000 and marker 8'hd0. With DROP_FILL=0 -> word 32'h11ffff00 keep 4'b1110 and marker 8'hd0.
- Full word pending with out_ready=0 for 5 cycles -> in_ready=0, out_data stable. Raise out_ready -> in_ready=1 the same cycle and the stream resumes with no byte lost.
- Assert rst_n low asynchronously after ff has been accepted, mid-word -> all outputs 0 immediately. Then send 00 11 22 33 -> word 32'h00112233; no ff is inserted.
